// File: rtl/calc_result_display_if.sv
// Valid/ready result channel from the add/sub stage to the display block.
interface calc_result_display_if;
    logic       res_valid;
    logic [4:0] res_data;
    logic       res_ready;

    modport master (output res_valid, output res_data, input res_ready);
    modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/calc_result_display.sv
// Captures a sign-magnitude result, holds it for a minimum time and drives
// a 4-digit multiplexed common-anode seven-segment display (sign, blank, tens, ones).
module calc_result_display #(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic                        clk,
    input  logic                        rst,
    calc_result_display_if.slave        res,
    input  logic                        clear,
    output logic [3:0]                  an,
    output logic [6:0]                  seg,
    output logic [4:0]                  shown_value,
    output logic                        busy
);
    localparam int unsigned REF_W  = 16;
    localparam int unsigned HOLD_W = 32;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;
    localparam logic [6:0]  SEG_MINUS = 7'b0111111;
    localparam logic [6:0]  SEG_ONE   = 7'b1111001;

    typedef enum logic [1:0] {BLANK, HOLD, SHOW} state_t;

    state_t              state, state_next;
    logic [REF_W-1:0]    ref_cnt;
    logic [1:0]          idx;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_next;
    logic [4:0]          held_next;
    logic                ready;
    logic                capture;
    logic                tens;
    logic [3:0]          ones;
    logic [3:0]          an_next;
    logic [6:0]          seg_next;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    // Ready is taken away in the reset cycle itself and for the whole hold.
    assign ready         = !rst && (state != HOLD);
    assign res.res_ready = ready;
    assign busy          = (state == HOLD);
    assign capture       = res.res_valid && ready && !clear;

    always_comb begin
        state_next    = state;
        held_next     = shown_value;
        hold_cnt_next = hold_cnt;
        case (state)
            BLANK, SHOW: begin
                if (capture) begin
                    state_next    = HOLD;
                    hold_cnt_next = '0;
                    held_next     = (res.res_data == 5'b10000) ? 5'b00000 : res.res_data;
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_next    = SHOW;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_next = BLANK;
        endcase
        if (clear) begin
            state_next    = BLANK;
            held_next     = '0;
            hold_cnt_next = '0;
        end
    end

    // Decode from the next held value so a new capture shows up one cycle later.
    always_comb begin
        tens     = (held_next[3:0] >= 4'd10);
        ones     = tens ? (held_next[3:0] - 4'd10) : held_next[3:0];
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        if (state_next != BLANK) begin
            an_next = ~(4'b0001 << idx);
            case (idx)
                2'd0:    seg_next = seg_of(ones);
                2'd1:    seg_next = tens ? SEG_ONE : SEG_BLANK;
                2'd2:    seg_next = SEG_BLANK;
                default: seg_next = held_next[4] ? SEG_MINUS : SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            hold_cnt    <= '0;
            shown_value <= '0;
            ref_cnt     <= '0;
            idx         <= '0;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            state       <= state_next;
            hold_cnt    <= hold_cnt_next;
            shown_value <= held_next;
            an          <= an_next;
            seg         <= seg_next;
            if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + REF_W'(1);
            end
        end
    end
endmodule
